// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and limits for the iterative shifter
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_NOP = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shf_state_t;

  localparam int SHIFT_MAX = 32;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift selected by op
import shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 32
) (
  input  shift_op_t        i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      SH_SLL:  o_data = {i_data[WIDTH-2:0], 1'b0};
      SH_SRL:  o_data = {1'b0, i_data[WIDTH-1:1]};
      SH_SRA:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - one-bit-per-clock shift unit with done pulse
import shift_pkg::*;

module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       Shift,
  input  logic [CNT_W-1:0] Num,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_MAX);

  shf_state_t       r_state;
  shf_state_t       w_state_nxt;
  shift_op_t        r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_step;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  // Shifting more than WIDTH steps cannot change the result further.
  always_comb begin
    w_load_cnt = (Num > CNT_MAX) ? CNT_MAX : Num;
    if (shift_op_t'(Shift) == SH_NOP) begin
      w_load_cnt = '0;
    end
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_op  (r_op),
    .i_data(r_dout),
    .o_data(w_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      r_cnt  <= '0;
      r_op   <= SH_SLL;
    end else if (w_accept) begin
      r_dout <= din;
      r_cnt  <= w_load_cnt;
      r_op   <= shift_op_t'(Shift);
    end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
      r_dout <= w_step;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign dout = r_dout;
  assign busy = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - directed self-checking bench for iterative_shifter
module tb_iterative_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  Shift;
  logic [5:0]  Num;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  iterative_shifter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .Shift(Shift),
    .Num  (Num),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at E0, scramble inputs afterwards, optionally pulse start at edge pulse_at.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] num,
                        input logic [31:0] d, input int pulse_at,
                        input logic [31:0] exp, input int exp_k);
    int k;
    int found;
    int extra;
    @(negedge clk);
    Shift = op; Num = num; din = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; din = ~d; Num = ~num; Shift = ~op;
    check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    found = 0;
    for (k = 1; k <= 80; k++) begin
      if (k == pulse_at) begin
        start = 1'b1;
        din = 32'hA5A5_A5A5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        found = k;
        break;
      end
    end
    check({tag, "_done_edge"}, found, exp_k);
    check({tag, "_dout"}, dout, exp);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    extra = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check({tag, "_no_extra_done"}, extra, 0);
    check({tag, "_dout_hold"}, dout, exp);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; Shift = 2'b00; Num = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("sll4",     2'b00, 6'd4,  32'h0000_0001, 0, 32'h0000_0010, 5);
    run_op("sra31",    2'b10, 6'd31, 32'h8000_0000, 0, 32'hFFFF_FFFF, 32);
    run_op("srl31",    2'b01, 6'd31, 32'h8000_0000, 0, 32'h0000_0001, 32);
    run_op("srl40",    2'b01, 6'd40, 32'hFFFF_FFFF, 0, 32'h0000_0000, 33);
    run_op("sra63",    2'b10, 6'd63, 32'h8000_1234, 0, 32'hFFFF_FFFF, 33);
    run_op("sra63pos", 2'b10, 6'd63, 32'h7000_1234, 0, 32'h0000_0000, 33);
    run_op("sll32",    2'b00, 6'd32, 32'hFFFF_FFFF, 0, 32'h0000_0000, 33);
    run_op("sll0",     2'b00, 6'd0,  32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
    run_op("nop7",     2'b11, 6'd7,  32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
    run_op("srl3",     2'b01, 6'd3,  32'hF000_0008, 0, 32'h1E00_0001, 4);
    run_op("busy_start", 2'b00, 6'd8, 32'h0000_0003, 3, 32'h0000_0300, 9);

    // Asynchronous reset between edges in the middle of a long shift.
    @(negedge clk);
    Shift = 2'b00; Num = 6'd20; din = 32'h0000_0001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_dout", dout, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 2'b10, 6'd4, 32'h8000_0000, 0, 32'hF800_0000, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
